// File: rtl/idma_obi_2d_midend_if.sv
// Bundle of every handshake and payload signal around the 2D midend.
// slave is the midend's view; master is the frontend/backend side.
interface idma_obi_2d_midend_if #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned TFLenWidth = 32,
    parameter int unsigned RepWidth   = 16
);
    logic                  nd_req_valid_i;
    logic                  nd_req_ready_o;
    logic [TFLenWidth-1:0] nd_length_i;
    logic [AddrWidth-1:0]  nd_src_addr_i;
    logic [AddrWidth-1:0]  nd_dst_addr_i;
    logic [AddrWidth-1:0]  nd_src_stride_i;
    logic [AddrWidth-1:0]  nd_dst_stride_i;
    logic [RepWidth-1:0]   nd_num_reps_i;

    logic                  req_valid_o;
    logic                  req_ready_i;
    logic [TFLenWidth-1:0] req_length_o;
    logic [AddrWidth-1:0]  req_src_addr_o;
    logic [AddrWidth-1:0]  req_dst_addr_o;
    logic                  req_last_o;

    logic                  rsp_valid_i;
    logic                  rsp_ready_o;
    logic                  rsp_error_i;

    logic                  nd_rsp_valid_o;
    logic                  nd_rsp_ready_i;
    logic                  nd_rsp_error_o;

    logic                  busy_o;

    modport slave (
        input  nd_req_valid_i, nd_length_i, nd_src_addr_i, nd_dst_addr_i,
               nd_src_stride_i, nd_dst_stride_i, nd_num_reps_i,
        output nd_req_ready_o,
        output req_valid_o, req_length_o, req_src_addr_o, req_dst_addr_o, req_last_o,
        input  req_ready_i,
        input  rsp_valid_i, rsp_error_i,
        output rsp_ready_o,
        output nd_rsp_valid_o, nd_rsp_error_o,
        input  nd_rsp_ready_i,
        output busy_o
    );

    modport master (
        output nd_req_valid_i, nd_length_i, nd_src_addr_i, nd_dst_addr_i,
               nd_src_stride_i, nd_dst_stride_i, nd_num_reps_i,
        input  nd_req_ready_o,
        input  req_valid_o, req_length_o, req_src_addr_o, req_dst_addr_o, req_last_o,
        output req_ready_i,
        output rsp_valid_i, rsp_error_i,
        input  rsp_ready_o,
        input  nd_rsp_valid_o, nd_rsp_error_o,
        output nd_rsp_ready_i,
        input  busy_o
    );
endinterface

// File: rtl/idma_obi_2d_midend.sv
// Splits one 2D job into num_reps strided 1D row requests and folds the
// backend responses back into a single 2D completion with sticky error.
//
// state | meaning
// IDLE  | waiting for a 2D job, nd_req_ready_o=1
// ISSUE | presenting rows to the backend, counting responses
// WAIT  | all rows issued, collecting remaining responses
// DONE  | completion presented until nd_rsp_ready_i
module idma_obi_2d_midend #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned TFLenWidth = 32,
    parameter int unsigned RepWidth   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    idma_obi_2d_midend_if.slave  bus
);
    localparam int unsigned CntWidth = RepWidth + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e                state_q;
    logic [TFLenWidth-1:0] len_q;
    logic [AddrWidth-1:0]  src_q, dst_q;
    logic [AddrWidth-1:0]  src_stride_q, dst_stride_q;
    logic [CntWidth-1:0]   total_q, issued_q, rsp_cnt_q;
    logic                  err_q;
    logic                  req_valid_q, req_last_q;
    logic                  nd_rsp_valid_q, nd_rsp_error_q;
    logic                  nd_req_ready_q, busy_q;

    logic                  issue_hs, rsp_hs, issue_final, rsp_final, err_d;
    logic [CntWidth-1:0]   issued_d, rsp_cnt_d, total_d, last_idx;

    assign issue_hs    = req_valid_q & bus.req_ready_i;
    assign rsp_hs      = bus.rsp_valid_i;
    assign issued_d    = issued_q + CntWidth'(1);
    assign rsp_cnt_d   = rsp_cnt_q + CntWidth'(1);
    assign last_idx    = total_q - CntWidth'(1);
    assign issue_final = (issued_d == total_q);
    assign rsp_final   = (rsp_cnt_d == total_q);
    assign err_d       = err_q | bus.rsp_error_i;
    // A repetition count of zero still moves one row.
    assign total_d     = (bus.nd_num_reps_i == '0) ? CntWidth'(1)
                                                   : CntWidth'(bus.nd_num_reps_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            len_q          <= '0;
            src_q          <= '0;
            dst_q          <= '0;
            src_stride_q   <= '0;
            dst_stride_q   <= '0;
            total_q        <= '0;
            issued_q       <= '0;
            rsp_cnt_q      <= '0;
            err_q          <= 1'b0;
            req_valid_q    <= 1'b0;
            req_last_q     <= 1'b0;
            nd_rsp_valid_q <= 1'b0;
            nd_rsp_error_q <= 1'b0;
            nd_req_ready_q <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.nd_req_valid_i) begin
                        len_q          <= bus.nd_length_i;
                        src_q          <= bus.nd_src_addr_i;
                        dst_q          <= bus.nd_dst_addr_i;
                        src_stride_q   <= bus.nd_src_stride_i;
                        dst_stride_q   <= bus.nd_dst_stride_i;
                        total_q        <= total_d;
                        issued_q       <= '0;
                        rsp_cnt_q      <= '0;
                        err_q          <= 1'b0;
                        req_valid_q    <= 1'b1;
                        req_last_q     <= (total_d == CntWidth'(1));
                        nd_req_ready_q <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rsp_hs) begin
                        rsp_cnt_q <= rsp_cnt_d;
                        err_q     <= err_d;
                    end
                    if (issue_hs) begin
                        issued_q   <= issued_d;
                        src_q      <= src_q + src_stride_q;
                        dst_q      <= dst_q + dst_stride_q;
                        req_last_q <= (issued_d == last_idx);
                        if (issue_final) begin
                            req_valid_q <= 1'b0;
                            req_last_q  <= 1'b0;
                            // The last response may land together with the last row.
                            if (rsp_hs ? rsp_final : (rsp_cnt_q == total_q)) begin
                                nd_rsp_valid_q <= 1'b1;
                                nd_rsp_error_q <= rsp_hs ? err_d : err_q;
                                state_q        <= DONE;
                            end else begin
                                state_q <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (rsp_hs) begin
                        rsp_cnt_q <= rsp_cnt_d;
                        err_q     <= err_d;
                        if (rsp_final) begin
                            nd_rsp_valid_q <= 1'b1;
                            nd_rsp_error_q <= err_d;
                            state_q        <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.nd_rsp_ready_i) begin
                        nd_rsp_valid_q <= 1'b0;
                        nd_rsp_error_q <= 1'b0;
                        nd_req_ready_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.nd_req_ready_o = nd_req_ready_q;
    assign bus.req_valid_o    = req_valid_q;
    assign bus.req_length_o   = len_q;
    assign bus.req_src_addr_o = src_q;
    assign bus.req_dst_addr_o = dst_q;
    assign bus.req_last_o     = req_last_q;
    // Responses are always sunk; outside ISSUE/WAIT they are simply dropped.
    assign bus.rsp_ready_o    = 1'b1;
    assign bus.nd_rsp_valid_o = nd_rsp_valid_q;
    assign bus.nd_rsp_error_o = nd_rsp_error_q;
    assign bus.busy_o         = busy_q;

endmodule
